// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Fetch entry bundle used between fetch buffer and decode.
package riscv_pkg;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: redirect in, imem req/rsp, decode handshake.
// master = fetch unit, slave = surrounding core/memory.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req_valid;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries.
// Flush wins over push/pop; head is read combinationally.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full,
  output fetch_entry_t head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = inc(wr_ptr_q);
      if (pop)  rd_ptr_d = inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests,
// response buffering and redirect flush with drop counting.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    head, push_entry;
  logic            push, pop, rsp_ok, req_fire;
  logic [CW:0]     used;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  // credit covers both buffered and in-flight words
  assign used = {1'b0, fifo_count} + {1'b0, out_q};

  assign bus.imem_req_valid = rst_n && !bus.redirect_valid
                           && (used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_ok   = bus.imem_rsp_valid && (out_q != '0);

  assign bus.inst_valid = rst_n && !fifo_empty && !bus.redirect_valid;
  assign bus.inst_data  = head.inst;
  assign bus.inst_pc    = head.pc;

  assign pop  = bus.inst_valid && bus.inst_ready;
  assign push = rsp_ok && (drop_q == '0) && !bus.redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    unique case (1'b1)
      bus.redirect_valid: begin
        fetch_pc_d = redir_pc;
        rsp_pc_d   = redir_pc;
        out_d      = out_q - CW'(rsp_ok);
        drop_d     = out_q - CW'(rsp_ok);
      end
      default: begin
        if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (rsp_ok) begin
          if (drop_q != '0) drop_d = drop_q - 1'b1;
          else rsp_pc_d = rsp_pc_q + PC_STEP;
        end
        out_d = out_q + CW'(req_fire) - CW'(rsp_ok);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (push_entry),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (head)
  );

  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.imem_rsp_valid && out_q == '0));

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an epoch-based
// model of the fetch stream and an in-order memory.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if ifc();

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  fetch_addr;
  int           epoch;
  int           cyc;
  int           n_cmp, n_mis;

  int  ready_pct, rsp_pct, irdy_pct, redir_pct;
  bit  rst_v, force_redir, force_rsp;
  logic [31:0] force_target;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic drive();
    bit can;
    rst_n = rst_v;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = $urandom;
    if (rst_v && (force_redir || ($urandom % 100) < redir_pct)) begin
      ifc.redirect_valid = 1'b1;
      if (force_redir) ifc.redirect_pc = force_target;
    end
    force_redir = 1'b0;
    ifc.imem_req_ready = (($urandom % 100) < ready_pct);
    ifc.inst_ready     = (($urandom % 100) < irdy_pct);
    can = rst_v && pend.size() > 0 && pend[0].due <= cyc;
    ifc.imem_rsp_valid = can && (force_rsp || ($urandom % 100) < rsp_pct);
    force_rsp = 1'b0;
    if (ifc.imem_rsp_valid) ifc.imem_rsp_data = pend[0].addr + 32'h100;
    else ifc.imem_rsp_data = $urandom;
  endtask

  task automatic tick();
    bit ev_req, ev_inst, redir, rv;
    fetch_entry_t e;
    pend_t p;
    @(negedge clk);
    redir  = ifc.redirect_valid;
    rv     = ifc.imem_rsp_valid;
    ev_req = rst_n && !redir && (exp_q.size() + pend.size() < 2);
    ev_inst = rst_n && !redir && exp_q.size() > 0;
    check_eq("req_valid", 32'(ifc.imem_req_valid), 32'(ev_req));
    if (ev_req) check_eq("req_addr", ifc.imem_req_addr, fetch_addr);
    check_eq("inst_valid", 32'(ifc.inst_valid), 32'(ev_inst));
    if (ev_inst) begin
      check_eq("inst_pc", ifc.inst_pc, exp_q[0].pc);
      check_eq("inst_data", ifc.inst_data, exp_q[0].inst);
    end
    @(posedge clk);
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      fetch_addr = 32'h0;
      epoch++;
    end else if (redir) begin
      exp_q.delete();
      if (rv) void'(pend.pop_front());
      fetch_addr = {ifc.redirect_pc[31:2], 2'b00};
      epoch++;
    end else begin
      if (ev_inst && ifc.inst_ready) void'(exp_q.pop_front());
      if (rv) begin
        p = pend.pop_front();
        if (p.epoch == epoch) begin
          e.pc   = p.addr;
          e.inst = p.addr + 32'h100;
          exp_q.push_back(e);
        end
      end
      if (ev_req && ifc.imem_req_ready) begin
        pend.push_back('{addr: fetch_addr, epoch: epoch, due: cyc + 1});
        fetch_addr = fetch_addr + 32'd4;
      end
    end
    cyc++;
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect_to(input logic [31:0] t, input bit with_rsp);
    force_redir  = 1'b1;
    force_target = t;
    force_rsp    = with_rsp;
    run(2);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; cyc = 0; epoch = 0;
    fetch_addr = 32'h0;
    rst_v = 1'b0; force_redir = 1'b0; force_rsp = 1'b0;
    force_target = '0;
    ready_pct = 100; rsp_pct = 100; irdy_pct = 100; redir_pct = 0;
    drive();
    run(3);
    rst_v = 1'b1;
    run(12);
    // decode stalls, then resumes
    irdy_pct = 0;
    run(10);
    irdy_pct = 100;
    run(5);
    // redirect with two requests in flight
    rsp_pct = 0;
    run(4);
    redirect_to(32'h8000_0003, 1'b0);
    rsp_pct = 100;
    run(10);
    // redirect coincident with a response
    rsp_pct = 0;
    run(4);
    redirect_to(32'h0000_4000, 1'b1);
    rsp_pct = 100;
    run(1);
    redirect_to(32'h1234_5678, 1'b0);
    run(10);
    // PC wrap
    redirect_to(32'hFFFF_FFFC, 1'b0);
    run(10);
    // reset with a full buffer
    irdy_pct = 0;
    run(6);
    rst_v = 1'b0;
    run(2);
    rst_v = 1'b1;
    irdy_pct = 100;
    run(10);
    // random traffic
    for (int blk = 0; blk < 60; blk++) begin
      ready_pct = $urandom_range(20, 100);
      rsp_pct   = $urandom_range(20, 100);
      irdy_pct  = $urandom_range(10, 100);
      redir_pct = $urandom_range(0, 8);
      for (int i = 0; i < 50; i++) begin
        rst_v = (($urandom % 300) != 0);
        run(1);
      end
    end
    rst_v = 1'b1;
    run(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the field-extraction decode stage.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them with a valid/ready handshake.
- inst_data drives the decode stage's 32-bit instruction input.
- Accepts redirects from execute (branch/jump), which flush buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on in-flight requests plus buffered entries

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active-low
redirect_valid  input  1  redirect PC this cycle
redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0)
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  word address of request (bits [1:0] always 0)
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  in-order response valid, at least 1 cycle after acceptance
imem_rsp_data  input  32  instruction word
inst_valid  output  1  instruction available to decode
inst_data  output  32  instruction word to decode
inst_pc  output  32  PC of inst_data
inst_ready  input  1  decode consumes the head entry

Behaviour:
- Reset (rst_n=0 at a clk edge): fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop=0, FIFO empty.
- While rst_n=0: imem_req_valid=0 and inst_valid=0.
- Request credit: imem_req_valid = rst_n && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - Request fires when imem_req_valid && imem_req_ready: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
- Response (imem_rsp_valid=1, outstanding>0): outstanding -= 1.
  - If drop>0: drop -= 1 and the word is discarded.
  - Else: push {rsp_pc, imem_rsp_data} into the FIFO and set rsp_pc += 4 (wraps).
- imem_rsp_valid with outstanding==0 is a protocol error: ignore it, no state change; flag with an assertion.
- Credit rule guarantees a push never hits a full FIFO. Push and pop in the same cycle are legal at any occupancy, including full.
- Output: inst_valid = FIFO non-empty && !redirect_valid; inst_data/inst_pc = FIFO head (combinational from storage).
  - Pop when inst_valid && inst_ready.
  - Head is stable while inst_valid=1 and inst_ready=0.
- Redirect (redirect_valid=1 at an edge), with r = {redirect_pc[31:2],2'b00}:
  - FIFO cleared; any pop or push that cycle is cancelled.
  - fetch_pc=r, rsp_pc=r.
  - No request issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - drop_next = outstanding - (imem_rsp_valid ? 1 : 0); outstanding_next = drop_next.
- Back-to-back redirects: the latest wins; drop accumulates via the same rule.
- Latency: the first request issues the cycle after reset release or the cycle after a redirect. The instruction is visible on inst_* the cycle after its response.
- Counters (outstanding, drop, fifo_count): width clog2(FIFO_DEPTH+1); never exceed FIFO_DEPTH.
- Reset mid-operation clears all state. The memory is expected to reset simultaneously; stray responses fall under the outstanding==0 rule.

Decomposition:
- Shared package riscv_pkg: XLEN=32, INST_W=32, PC_STEP=4, typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: count, empty, full, head.
  - Flush has priority over push/pop.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr+0x100: requests at 0x0, 0x4; inst_pc 0x0 then 0x4 with data 0x100, 0x104; requests never exceed credit 2.
- inst_ready=0 for 10 cycles: at most 2 requests outstanding plus buffered; inst_data 0x100 held stable; after inst_ready=1, 0x104 follows the next cycle, no loss or duplication.
- Redirect to 0x8000_0003 with 2 requests outstanding: both responses dropped, FIFO empty, next request addr 0x8000_0000, first delivered inst_pc 0x8000_0000.
- Redirect coincident with a response and with inst_ready=1: response discarded, no pop reported, drop=1 remaining; following redirect target is fetched correctly.
- fetch_pc=0xFFFF_FFFC: next request addr wraps to 0x0000_0000; inst_pc sequence 0xFFFF_FFFC, 0x0.
- Assert rst_n=0 mid-stream with FIFO full: next cycle inst_valid=0, imem_req_valid=0; after release, fetch restarts at RESET_PC.
